// File: rtl/hazard_controller_if.sv
// ---------------------------------------------------------------------------
// Module   : hazard_controller_if
// Brief    : Pipeline-state inputs and stall/flush/counter outputs of the
//            hazard controller, bundled for port connection.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

interface hazard_controller_if #(
    parameter int CNT_W = 16
);
    logic [31:0]      instruction_IFID_IDEX;
    logic [4:0]       rd_EX;
    logic             regWrite_EX;
    logic             memRead_EX;
    logic [4:0]       rd_MEM;
    logic             regWrite_MEM;
    logic             memRead_MEM;
    logic             memWrite_MEM;
    logic             dmem_ready;
    logic             takeBranch;
    logic             perf_clr;

    logic             stall_PC;
    logic             stall_IFID;
    logic             bubble_IDEX;
    logic             stall_IDEX;
    logic             stall_EXMEM;
    logic             bubble_MEMWB;
    logic             flush_IFID;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] flush_count;

    modport master (
        output instruction_IFID_IDEX, rd_EX, regWrite_EX, memRead_EX,
               rd_MEM, regWrite_MEM, memRead_MEM, memWrite_MEM,
               dmem_ready, takeBranch, perf_clr,
        input  stall_PC, stall_IFID, bubble_IDEX, stall_IDEX, stall_EXMEM,
               bubble_MEMWB, flush_IFID, mem_timeout, stall_count, flush_count
    );

    modport slave (
        input  instruction_IFID_IDEX, rd_EX, regWrite_EX, memRead_EX,
               rd_MEM, regWrite_MEM, memRead_MEM, memWrite_MEM,
               dmem_ready, takeBranch, perf_clr,
        output stall_PC, stall_IFID, bubble_IDEX, stall_IDEX, stall_EXMEM,
               bubble_MEMWB, flush_IFID, mem_timeout, stall_count, flush_count
    );
endinterface

`default_nettype wire

// File: rtl/hazard_controller.sv
// ---------------------------------------------------------------------------
// Module   : hazard_controller
// Brief    : Load-use / decode-branch hazard detection, data-memory freeze
//            with timeout release, and saturating stall/flush counters.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module hazard_controller #(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 64
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    hazard_controller_if.slave bus
);
    localparam int               C_WCW   = $clog2(MEM_TIMEOUT + 1);
    localparam logic [C_WCW-1:0] C_LIMIT = C_WCW'(MEM_TIMEOUT - 1);
    localparam logic [C_WCW-1:0] C_WONE  = C_WCW'(1);
    localparam logic [CNT_W-1:0] C_CONE  = CNT_W'(1);

    localparam logic [6:0] C_OP_R    = 7'b0110011;
    localparam logic [6:0] C_OP_IALU = 7'b0010011;
    localparam logic [6:0] C_OP_LOAD = 7'b0000011;
    localparam logic [6:0] C_OP_STOR = 7'b0100011;
    localparam logic [6:0] C_OP_BR   = 7'b1100011;
    localparam logic [6:0] C_OP_JALR = 7'b1100111;

    typedef enum logic [0:0] {
        S_RUN  = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [C_WCW-1:0]   r_wait_cnt, w_wait_cnt_nxt;
    logic               r_mem_timeout;
    logic [CNT_W-1:0]   r_stall_count, r_flush_count;

    logic [6:0]  w_opcode;
    logic [4:0]  w_rs1, w_rs2;
    logic        w_use_rs1, w_use_rs2, w_is_br;
    logic        w_ex_match, w_mem_match;
    logic        w_load_use, w_dec_hz, w_data_stall;
    logic        w_mem_req, w_mem_wait, w_release, w_to_set;
    logic        w_flush;
    logic        w_unused_bits;

    assign w_opcode      = bus.instruction_IFID_IDEX[6:0];
    assign w_rs1         = bus.instruction_IFID_IDEX[19:15];
    assign w_rs2         = bus.instruction_IFID_IDEX[24:20];
    assign w_unused_bits = ^{bus.instruction_IFID_IDEX[31:25], bus.instruction_IFID_IDEX[14:7]};

    assign w_use_rs1 = (w_opcode == C_OP_R)    || (w_opcode == C_OP_IALU) ||
                       (w_opcode == C_OP_LOAD) || (w_opcode == C_OP_STOR) ||
                       (w_opcode == C_OP_BR)   || (w_opcode == C_OP_JALR);
    assign w_use_rs2 = (w_opcode == C_OP_R) || (w_opcode == C_OP_STOR) ||
                       (w_opcode == C_OP_BR);
    assign w_is_br   = (w_opcode == C_OP_BR) || (w_opcode == C_OP_JALR);

    // Non-zero rs required: a match on x0 never creates a dependency
    assign w_ex_match  = (w_use_rs1 && (w_rs1 != 5'd0) && (w_rs1 == bus.rd_EX)) ||
                         (w_use_rs2 && (w_rs2 != 5'd0) && (w_rs2 == bus.rd_EX));
    assign w_mem_match = (w_use_rs1 && (w_rs1 != 5'd0) && (w_rs1 == bus.rd_MEM)) ||
                         (w_use_rs2 && (w_rs2 != 5'd0) && (w_rs2 == bus.rd_MEM));

    assign w_load_use   = bus.memRead_EX && w_ex_match;
    assign w_dec_hz     = w_is_br && ((bus.regWrite_EX && w_ex_match) ||
                          (bus.regWrite_MEM && bus.memRead_MEM && w_mem_match));
    assign w_data_stall = w_load_use || w_dec_hz;

    assign w_mem_req  = bus.memRead_MEM || bus.memWrite_MEM;
    assign w_mem_wait = w_mem_req && !bus.dmem_ready && !w_release;
    assign w_flush    = bus.takeBranch && !w_data_stall && !w_mem_wait;

    always_comb begin
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        w_release      = 1'b0;
        w_to_set       = 1'b0;
        case (r_state)
            S_RUN: begin
                if (w_mem_req && !bus.dmem_ready) begin
                    w_state_nxt    = S_WAIT;
                    w_wait_cnt_nxt = C_WONE;
                end
            end
            S_WAIT: begin
                if (!w_mem_req || bus.dmem_ready) begin
                    w_state_nxt    = S_RUN;
                    w_wait_cnt_nxt = '0;
                end else if (r_wait_cnt == C_LIMIT) begin
                    w_release      = 1'b1;
                    w_to_set       = 1'b1;
                    w_state_nxt    = S_RUN;
                    w_wait_cnt_nxt = '0;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt + C_WONE;
                end
            end
            default: begin
                w_state_nxt    = S_RUN;
                w_wait_cnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_RUN;
            r_wait_cnt    <= '0;
            r_mem_timeout <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
            if (w_to_set) begin
                r_mem_timeout <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_count <= '0;
            r_flush_count <= '0;
        end else if (bus.perf_clr) begin
            r_stall_count <= '0;
            r_flush_count <= '0;
        end else begin
            if ((w_data_stall || w_mem_wait) && !(&r_stall_count)) begin
                r_stall_count <= r_stall_count + C_CONE;
            end
            if (w_flush && !(&r_flush_count)) begin
                r_flush_count <= r_flush_count + C_CONE;
            end
        end
    end

    // Freeze takes priority; all controls forced low while reset is held
    always_comb begin
        bus.stall_PC     = 1'b0;
        bus.stall_IFID   = 1'b0;
        bus.bubble_IDEX  = 1'b0;
        bus.stall_IDEX   = 1'b0;
        bus.stall_EXMEM  = 1'b0;
        bus.bubble_MEMWB = 1'b0;
        bus.flush_IFID   = 1'b0;
        if (rst_n) begin
            if (w_mem_wait) begin
                bus.stall_PC     = 1'b1;
                bus.stall_IFID   = 1'b1;
                bus.stall_IDEX   = 1'b1;
                bus.stall_EXMEM  = 1'b1;
                bus.bubble_MEMWB = 1'b1;
            end else if (w_data_stall) begin
                bus.stall_PC    = 1'b1;
                bus.stall_IFID  = 1'b1;
                bus.bubble_IDEX = 1'b1;
            end
            bus.flush_IFID = w_flush;
        end
    end

    assign bus.mem_timeout = r_mem_timeout;
    assign bus.stall_count = r_stall_count;
    assign bus.flush_count = r_flush_count;
endmodule

`default_nettype wire

// File: doc/hazard_controller.md
# hazard_controller

Pipeline hazard and sequencing controller for the 5-stage RV32I core with decode-stage branch resolution. It watches the instruction in ID and the destination and control fields of EX and MEM. It produces the stall, bubble and flush controls for PC, IF/ID, ID/EX, EX/MEM and MEM/WB, and freezes the pipeline while the data memory is not ready. It also keeps saturating performance counters for stall and flush cycles.

## Interface
- CNT_W, 16, width of each performance counter
- MEM_TIMEOUT, 64, maximum number of consecutive MEMWAIT cycles before a forced release (≥2)

Ports:
- clk  in  1  core clock
- rst_n  in  1  reset, asynchronous, active-low
- instruction_IFID_IDEX  in  32  instruction currently in ID
- rd_EX  in  5  destination register of the ID/EX instruction
- regWrite_EX  in  1  ID/EX instruction writes a register
- memRead_EX  in  1  ID/EX instruction is a load
- rd_MEM  in  5  destination register of the EX/MEM instruction
- regWrite_MEM  in  1  EX/MEM instruction writes a register
- memRead_MEM  in  1  EX/MEM instruction is a load
- memWrite_MEM  in  1  EX/MEM instruction is a store
- dmem_ready  in  1  data memory completes the MEM access this cycle
- takeBranch  in  1  branch unit redirect from ID
- perf_clr  in  1  synchronous clear of both counters
- stall_PC, stall_IFID  out  1 each  hold the register
- bubble_IDEX  out  1  load a NOP into ID/EX
- stall_IDEX, stall_EXMEM  out  1 each  hold the register
- bubble_MEMWB  out  1  load a NOP into MEM/WB
- flush_IFID  out  1  replace IF/ID with a NOP
- mem_timeout  out  1  sticky flag: a memory wait reached MEM_TIMEOUT
- stall_count, flush_count  out  CNT_W each  saturating counters

## Operation
- Decode of the instruction in ID uses opcode [6:0].
  - rs1 is used for R 0110011, I-ALU 0010011, load 0000011, store 0100011, branch 1100011 and JALR 1100111.
  - rs2 is used for R, store and branch.
  - A match against x0 is never a hazard.
- Load-use hazard: memRead_EX, rd_EX≠0, and rd_EX equals a used rs.
- Decode-resolve hazard applies only when ID holds a branch or JALR, and fires on either condition:
  - regWrite_EX with rd_EX≠0 matching a used rs;
  - regWrite_MEM && memRead_MEM with rd_MEM≠0 matching a used rs.
  - A non-load result in MEM is forwarded to ID and does not stall.
- data_stall is the OR of the two hazards. Its response is stall_PC=1, stall_IFID=1, bubble_IDEX=1.
- Memory freeze: mem_wait = (memRead_MEM|memWrite_MEM) && !dmem_ready && !release.
  - Response: stall_PC, stall_IFID, stall_IDEX and stall_EXMEM are 1, and bubble_MEMWB=1.
  - bubble_IDEX=0 and flush_IFID=0.
  - mem_wait overrides data_stall: the data hazard is re-evaluated after the freeze.
- Flush: flush_IFID = takeBranch && !data_stall && !mem_wait. A takeBranch during data_stall is ignored because the operands are stale.
- FSM states:
  - RUN → WAIT when mem_wait.
  - WAIT → RUN when dmem_ready, or when the memory request drops.
  - WAIT counts wait_cnt from 1. When wait_cnt = MEM_TIMEOUT−1, release=1 for that cycle, which deasserts the freeze; mem_timeout is set and the state goes to RUN.
  - release is only asserted in WAIT.
- Counters:
  - stall_count increments on any cycle with data_stall|mem_wait.
  - flush_count increments on any cycle with flush_IFID.
  - Both saturate at all ones.
  - perf_clr zeroes both and wins over increment.
  - mem_timeout is cleared only by reset.

## Timing
- Reset (asynchronous assert) sets:
  - state=RUN, wait_cnt=0, mem_timeout=0, both counters 0.
  - All stall, bubble and flush outputs read 0 while rst_n=0.
- Control outputs are combinational from inputs and state, with zero latency. FSM, counters and mem_timeout are registered and update at the clock edge.
- A load-use stall lasts exactly 1 cycle.
- A branch depending on an ALU op in EX stalls 1 cycle.
- A branch depending on a load in EX stalls 2 cycles: the first as load-use, the second as the load-in-MEM case.
- A memory wait of N not-ready cycles freezes the pipeline for exactly N cycles when N < MEM_TIMEOUT−1.
- Simultaneous mem_wait, data_stall and takeBranch: only the freeze outputs assert, and stall_count increments by 1.
- If reset is asserted mid-WAIT, the controller returns to RUN immediately and drops the freeze.

## Test plan
- lw x5 in EX (memRead_EX=1, rd_EX=5) with add x6,x5,x1 in ID -> exactly one cycle of stall_PC=stall_IFID=bubble_IDEX=1; stall_count=1.
- beq x7,x0 in ID with lw x7 in EX -> stall for 2 consecutive cycles; the same beq with lw x7 in MEM only -> 1 stall; with add x7 in MEM -> 0 stalls, and flush_IFID=1 when takeBranch=1.
- Store in MEM with dmem_ready low for 3 cycles -> freeze outputs high for 3 cycles, FSM RUN→WAIT→RUN, bubble_MEMWB=1 throughout, mem_timeout=0.
- MEM_TIMEOUT=4, load in MEM, dmem_ready held 0 -> freeze for 3 cycles, then released with mem_timeout=1 (sticky).
- takeBranch=1 together with a load-use hazard -> flush_IFID=0; takeBranch=1 with x0 as the only source match -> flush_IFID=1 and no stall.
- Drive 2^CNT_W+5 stall cycles -> stall_count saturates at all ones; perf_clr=1 in the same cycle as a stall -> counter reads 0.
